// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types, defaults and GF(2^8) helpers for the AES-128 key schedule controller.
package key_schedule_ctrl_pkg;

  localparam int NUM_ROUNDS_DEF = 10;
  localparam int ADDR_W_DEF     = 4;

  // Entry 0 and entries past 10 are unused rounds and read as zero.
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    return RCON[round];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Inverse as x^254 (x^127 by repeated square-multiply, then one square); 0 maps to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      inv = gf_mul(gf_mul(inv, inv), x);
    end
    inv = gf_mul(inv, inv);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/round_key_step.sv
// One AES-128 key-expansion round: RotWord/SubWord/Rcon on word3, then the XOR chain.
module round_key_step
  import key_schedule_ctrl_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_w[8*b +: 8] = sbox(rot_w[8*b +: 8]);
  end

  assign t  = sub_w ^ {rcon(round), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Key schedule controller: accepts a cipher key, expands one round key per cycle into storage.
//   state  | meaning
//   IDLE   | no valid schedule, waiting for a key
//   EXPAND | writing rk[round_q] each cycle
//   READY  | all round keys valid, a new key restarts expansion
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [ADDR_W-1:0] rk_addr,
  output logic [127:0]      rk_data,
  output logic              keys_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_RND = ADDR_W'(NUM_ROUNDS);

  ks_state_e         state_q, state_d;
  logic [ADDR_W-1:0] round_q, round_d;
  logic              keys_valid_q, keys_valid_d;
  logic [127:0]      rk_data_q, rk_data_d;
  logic [127:0]      rk_q [NUM_ROUNDS+1];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0]      wr_data;
  logic [ADDR_W-1:0] prev_idx;
  logic [127:0]      step_key;

  assign prev_idx = (round_q == '0) ? '0 : round_q - ADDR_W'(1);

  round_key_step u_step (
    .prev_key (rk_q[prev_idx]),
    .round    (4'(round_q)),
    .next_key (step_key)
  );

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = keys_valid_q;
  assign rk_data    = rk_data_q;

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    keys_valid_d = keys_valid_q;
    wr_en        = 1'b0;
    wr_addr      = round_q;
    wr_data      = step_key;
    case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          state_d      = EXPAND;
          round_d      = ADDR_W'(1);
          keys_valid_d = 1'b0;
          wr_en        = 1'b1;
          wr_addr      = '0;
          wr_data      = key_in;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        if (round_q == LAST_RND) begin
          state_d      = READY;
          keys_valid_d = 1'b1;
        end else begin
          round_d = round_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered read samples storage before this edge's write lands (read-before-write).
  assign rk_data_d = (rk_addr <= LAST_RND) ? rk_q[rk_addr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      round_q      <= '0;
      keys_valid_q <= 1'b0;
      rk_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      keys_valid_q <= keys_valid_d;
      rk_data_q    <= rk_data_d;
      if (wr_en) rk_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a FIPS-197 word-array key expansion model.
module tb_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         keys_valid;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb [256];
  logic [7:0]   rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_rk [11];
  logic [127:0] old_rk [11];

  key_schedule_ctrl #(.NUM_ROUNDS(10), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 8'h01) acc = acc ^ sh;
      sh = (sh << 1) ^ ((sh & 8'h80) != 0 ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && xtime_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic compute_sched(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (96 - 32 * i));
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc[i/4-1], 24'h000000};
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k, input string tag);
    check({tag, " ready_before"}, 128'(key_ready), 128'(1));
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_in    = rand_key();
    check({tag, " busy_after_accept"}, 128'(busy), 128'(1));
    check({tag, " kv_cleared"}, 128'(keys_valid), 128'(0));
  endtask

  task automatic wait_valid(input int start, input string tag);
    int lat;
    lat = start;
    while (!keys_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(10));
    check({tag, " busy_done"}, 128'(busy), 128'(0));
  endtask

  task automatic read_chk(input int a, input logic [127:0] exp, input string tag);
    rk_addr = 4'(a);
    tick();
    check(tag, rk_data, exp);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 11; a++) read_chk(a, exp_rk[a], $sformatf("%s rk[%0d]", tag, a));
  endtask

  initial begin
    logic [127:0] k;
    int a;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_addr   = '0;
    build_sbox();
    tick();
    tick();
    check("reset keys_valid", 128'(keys_valid), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset rk_data", rk_data, 128'(0));
    rst = 1'b0;
    check("reset key_ready", 128'(key_ready), 128'(1));

    // FIPS-197 vector
    compute_sched(FIPS_KEY);
    do_load(FIPS_KEY, "fips");
    wait_valid(0, "fips");
    read_chk(1, 128'ha0fafe1788542cb123a339392a6c7605, "fips rk1 const");
    read_chk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips rk10 const");
    read_all("fips");

    // All-zero key, loaded from READY
    compute_sched(128'h0);
    do_load(128'h0, "zero");
    wait_valid(0, "zero");
    read_chk(1, 128'h62636363626363636263636362636363, "zero rk1 const");
    read_chk(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero rk10 const");

    // Read-before-write while reloading from READY
    old_rk = exp_rk;
    k = rand_key();
    compute_sched(k);
    do_load(k, "rbw");
    rk_addr = 4'd1;
    tick();
    check("rbw old rk1", rk_data, old_rk[1]);
    rk_addr = 4'd1;
    tick();
    check("rbw new rk1", rk_data, exp_rk[1]);
    wait_valid(2, "rbw");
    read_all("rbw");

    // Key spam during EXPAND must be ignored
    k = rand_key();
    compute_sched(k);
    do_load(k, "spam");
    for (int j = 1; j <= 10; j++) begin
      key_in    = rand_key();
      key_valid = 1'b1;
      tick();
      if (j < 10) begin
        check($sformatf("spam ready j%0d", j), 128'(key_ready), 128'(0));
        check($sformatf("spam kv j%0d", j), 128'(keys_valid), 128'(0));
      end
    end
    key_valid = 1'b0;
    check("spam kv final", 128'(keys_valid), 128'(1));
    read_all("spam");

    // Reset at round 5, together with a key offer
    do_load(FIPS_KEY, "abort");
    for (int j = 0; j < 4; j++) tick();
    check("abort busy mid", 128'(busy), 128'(1));
    rst       = 1'b1;
    key_valid = 1'b1;
    key_in    = rand_key();
    tick();
    rst       = 1'b0;
    key_valid = 1'b0;
    check("abort kv", 128'(keys_valid), 128'(0));
    check("abort busy", 128'(busy), 128'(0));
    check("abort rk_data", rk_data, 128'(0));
    check("abort ready", 128'(key_ready), 128'(1));
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("abort kv hold %0d", j), 128'(keys_valid), 128'(0));
    end
    compute_sched(FIPS_KEY);
    do_load(FIPS_KEY, "reload");
    wait_valid(0, "reload");
    read_chk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "reload rk10 const");

    // Out-of-range reads
    read_chk(15, 128'h0, "oor addr15");
    read_chk(11, 128'h0, "oor addr11");

    // Random keys with random reads
    for (int it = 0; it < 5; it++) begin
      k = rand_key();
      compute_sched(k);
      do_load(k, $sformatf("rnd%0d", it));
      wait_valid(0, $sformatf("rnd%0d", it));
      for (int r = 0; r < 8; r++) begin
        a = int'($urandom_range(0, 15));
        read_chk(a, (a <= 10) ? exp_rk[a] : 128'h0, $sformatf("rnd%0d addr%0d", it, a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
